wb_write_port: RTL

Writeback write-port sequencer for the 64-bit ARMv8 core. It takes results from two writeback sources: the ALU and the memory/multi-cycle unit. It queues them in arrival order and drives the register file's single write port (RegWr/RW/BusW) with at most one write per cycle. Writes to X31 (XZR) are discarded. It sits between the execute/memory stages and the register file, and exports a pending-write scoreboard for decode hazard checks.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_write_port_if.sv | 44 ++++
 rtl/wb_fifo.sv | 99 +++++++++
 rtl/wb_write_port.sv | 120 ++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared constants and types for the writeback write-port sequencer.
//   XZR_ADDR    : architectural zero register, writes to it are dropped
//   REG_ADDR_W  : register-file address width
//   NUM_REGS    : number of architectural registers (width of Pending)
//   WB_DATA_W   : default result width
//   wb_entry_t  : one queued write {rd, data} at the default width
// ---------------------------------------------------------------------------
package wb_pkg;

   localparam logic [4:0] XZR_ADDR   = 5'd31;
   localparam int         REG_ADDR_W = 5;
   localparam int         NUM_REGS   = 32;
   localparam int         WB_DATA_W  = 64;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0]  data;
   } wb_entry_t;

endpackage

// File: rtl/wb_write_port_if.sv
// ---------------------------------------------------------------------------
// wb_write_port_if
// Bundle of the two writeback sources and the register-file write port.
//   MemValid/MemRd/MemData -> MemReady : memory/multi-cycle unit result
//   AluValid/AluRd/AluData -> AluReady : ALU result
//   RegWr/RW/BusW                      : register-file write port
// Modports:
//   slave  : the sequencer (consumes results, drives the write port)
//   master : the environment (produces results, observes the write port)
// ---------------------------------------------------------------------------
interface wb_write_port_if #(
   parameter int DATA_W = 64
);
   import wb_pkg::*;

   logic                  MemValid;
   logic [REG_ADDR_W-1:0] MemRd;
   logic [DATA_W-1:0]     MemData;
   logic                  MemReady;

   logic                  AluValid;
   logic [REG_ADDR_W-1:0] AluRd;
   logic [DATA_W-1:0]     AluData;
   logic                  AluReady;

   logic                  RegWr;
   logic [REG_ADDR_W-1:0] RW;
   logic [DATA_W-1:0]     BusW;

   modport slave (
      input  MemValid, MemRd, MemData,
      input  AluValid, AluRd, AluData,
      output MemReady, AluReady,
      output RegWr, RW, BusW
   );

   modport master (
      output MemValid, MemRd, MemData,
      output AluValid, AluRd, AluData,
      input  MemReady, AluReady,
      input  RegWr, RW, BusW
   );

endinterface

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// DEPTH-entry FIFO of {rd, data} with two push ports and one pop port.
// Push port 0 is written ahead of push port 1 when both fire on one edge.
// The caller guarantees pushes never exceed free space and pop only when
// count > 0.
// Ports:
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_push0/i_rd0/i_data0     : first push (older)
//   i_push1/i_rd1/i_data1     : second push (younger)
//   i_pop                     : remove head
//   o_count                   : occupancy 0..DEPTH
//   o_head_rd/o_head_data     : head entry
//   o_valid/o_rd_flat         : per-slot valid and rd (WB_SCOREBOARD_EN only)
// ---------------------------------------------------------------------------
module wb_fifo
   import wb_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int DATA_W = 64,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_push0,
   input  logic [REG_ADDR_W-1:0]       i_rd0,
   input  logic [DATA_W-1:0]           i_data0,
   input  logic                        i_push1,
   input  logic [REG_ADDR_W-1:0]       i_rd1,
   input  logic [DATA_W-1:0]           i_data1,
   input  logic                        i_pop,
   output logic [CNT_W-1:0]            o_count,
   output logic [REG_ADDR_W-1:0]       o_head_rd,
   output logic [DATA_W-1:0]           o_head_data
`ifdef WB_SCOREBOARD_EN
   ,
   output logic [DEPTH-1:0]            o_valid,
   output logic [DEPTH*REG_ADDR_W-1:0] o_rd_flat
`endif
);

   logic [REG_ADDR_W-1:0] r_rd   [DEPTH];
   logic [DATA_W-1:0]     r_data [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   logic [PTR_W-1:0]      w_wr_ptr1;
   logic [1:0]            w_n_push;

   assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);
   assign w_n_push  = {1'b0, i_push0} + {1'b0, i_push1};

   // Slot contents need no reset: occupancy alone decides what is live.
   always_ff @(posedge i_clk) begin
      if (i_push0) begin
         r_rd[r_wr_ptr]   <= i_rd0;
         r_data[r_wr_ptr] <= i_data0;
      end else if (i_push1) begin
         r_rd[r_wr_ptr]   <= i_rd1;
         r_data[r_wr_ptr] <= i_data1;
      end
      if (i_push0 && i_push1) begin
         r_rd[w_wr_ptr1]   <= i_rd1;
         r_data[w_wr_ptr1] <= i_data1;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_push);
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_n_push) - CNT_W'(i_pop);
      end
   end

   assign o_count     = r_count;
   assign o_head_rd   = r_rd[r_rd_ptr];
   assign o_head_data = r_data[r_rd_ptr];

`ifdef WB_SCOREBOARD_EN
   // A slot is live when its distance from the read pointer is below count.
   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      logic [PTR_W-1:0] w_off;
      assign w_off      = PTR_W'(g) - r_rd_ptr;
      assign o_valid[g] = {1'b0, w_off} < r_count;
      assign o_rd_flat[g*REG_ADDR_W +: REG_ADDR_W] = r_rd[g];
   end
`endif

endmodule

// File: rtl/wb_write_port.sv
// ---------------------------------------------------------------------------
// wb_write_port
// Writeback write-port sequencer. Accepts ALU and memory-unit results,
// drops writes to XZR, queues the rest in arrival order (memory ahead of
// ALU on the same edge) and drives the single register-file write port
// one write per cycle from a registered output stage.
// Ports:
//   Clk      : clock
//   Reset_n  : asynchronous active-low reset
//   bus      : wb_write_port_if.slave (sources, readies, RegWr/RW/BusW)
//   Pending  : per-register pending-write scoreboard (WB_SCOREBOARD_EN only)
// Parameters:
//   DEPTH    : queue entries, power of two, >= 2
//   DATA_W   : result width
// Build option: define WB_SCOREBOARD_EN to add the Pending port and logic.
// ---------------------------------------------------------------------------
module wb_write_port
   import wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 64
) (
   input  logic                Clk,
   input  logic                Reset_n,
   wb_write_port_if.slave      bus
`ifdef WB_SCOREBOARD_EN
   ,
   output logic [NUM_REGS-1:0] Pending
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [CNT_W-1:0]      w_count;
   logic [REG_ADDR_W-1:0] w_head_rd;
   logic [DATA_W-1:0]     w_head_data;
   logic                  w_mem_ready;
   logic                  w_alu_ready;
   logic                  w_mem_push;
   logic                  w_alu_push;
   logic                  w_pop;

   logic                  r_reg_wr;
   logic [REG_ADDR_W-1:0] r_rw;
   logic [DATA_W-1:0]     r_busw;

   // Readiness is judged on pre-edge occupancy only; a same-cycle pop does
   // not free a slot. The ALU sees the slot the memory unit is taking.
   assign w_mem_ready = w_count < CNT_W'(DEPTH);
   assign w_mem_push  = bus.MemValid && w_mem_ready && (bus.MemRd != XZR_ADDR);
   assign w_alu_ready = (w_count + CNT_W'(w_mem_push)) < CNT_W'(DEPTH);
   assign w_alu_push  = bus.AluValid && w_alu_ready && (bus.AluRd != XZR_ADDR);
   assign w_pop       = w_count != '0;

   assign bus.MemReady = w_mem_ready;
   assign bus.AluReady = w_alu_ready;

`ifdef WB_SCOREBOARD_EN
   logic [DEPTH-1:0]            w_ent_valid;
   logic [DEPTH*REG_ADDR_W-1:0] w_ent_rd;
`endif

   wb_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .i_clk       (Clk),
      .i_rst_n     (Reset_n),
      .i_push0     (w_mem_push),
      .i_rd0       (bus.MemRd),
      .i_data0     (bus.MemData),
      .i_push1     (w_alu_push),
      .i_rd1       (bus.AluRd),
      .i_data1     (bus.AluData),
      .i_pop       (w_pop),
      .o_count     (w_count),
      .o_head_rd   (w_head_rd),
      .o_head_data (w_head_data)
`ifdef WB_SCOREBOARD_EN
      ,
      .o_valid     (w_ent_valid),
      .o_rd_flat   (w_ent_rd)
`endif
   );

   // Output stage: drains every cycle; RW/BusW hold when idle.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_reg_wr <= 1'b0;
         r_rw     <= '0;
         r_busw   <= '0;
      end else begin
         r_reg_wr <= w_pop;
         if (w_pop) begin
            r_rw   <= w_head_rd;
            r_busw <= w_head_data;
         end
      end
   end

   assign bus.RegWr = r_reg_wr;
   assign bus.RW    = r_rw;
   assign bus.BusW  = r_busw;

`ifdef WB_SCOREBOARD_EN
   always_comb begin
      Pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_ent_valid[i]) begin
            Pending[w_ent_rd[i*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
         end
      end
      if (r_reg_wr) begin
         Pending[r_rw] = 1'b1;
      end
      Pending[XZR_ADDR] = 1'b0;
   end
`endif

endmodule
